// File: rtl/cpu_wb_unit_pkg.sv
// Shared types for the CPU writeback unit: load-queue entry layout and load data formatting.
package cpu_wb_unit_pkg;

    localparam int CPU_ADDR_WIDTH = 5;
    localparam int CPU_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        LQ_LB  = 3'b000,
        LQ_LH  = 3'b001,
        LQ_LW  = 3'b010,
        LQ_LBU = 3'b100,
        LQ_LHU = 3'b101
    } lq_type_t;

    typedef struct packed {
        logic [CPU_ADDR_WIDTH-1:0] rd;
        lq_type_t                  ltype;
        logic [1:0]                offset;
    } lq_entry_t;

    // Extracts the addressed byte/half from an aligned word; unlisted funct3 codes pass the word through.
    function automatic logic [CPU_DATA_WIDTH-1:0] lq_format(
        input lq_type_t                  ltype,
        input logic [1:0]                offset,
        input logic [CPU_DATA_WIDTH-1:0] raw
    );
        logic [7:0]                byteSel;
        logic [15:0]               halfSel;
        logic [CPU_DATA_WIDTH-1:0] res;
        case (offset)
            2'd0:    byteSel = raw[7:0];
            2'd1:    byteSel = raw[15:8];
            2'd2:    byteSel = raw[23:16];
            default: byteSel = raw[31:24];
        endcase
        halfSel = offset[1] ? raw[31:16] : raw[15:0];
        case (ltype)
            LQ_LB:   res = {{(CPU_DATA_WIDTH-8){byteSel[7]}}, byteSel};
            LQ_LH:   res = {{(CPU_DATA_WIDTH-16){halfSel[15]}}, halfSel};
            LQ_LBU:  res = {{(CPU_DATA_WIDTH-8){1'b0}}, byteSel};
            LQ_LHU:  res = {{(CPU_DATA_WIDTH-16){1'b0}}, halfSel};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cpu_wb_unit_if.sv
// Bus bundle between issue/memory logic and the writeback unit.
// The bypass signals exist only when CPU_WB_BYPASS_EN is defined.
interface cpu_wb_unit_if
    import cpu_wb_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int DATA_WIDTH = CPU_DATA_WIDTH
);
    logic                     alu_valid;
    logic [ADDR_WIDTH-1:0]    alu_rd;
    logic [DATA_WIDTH-1:0]    alu_data;
    logic                     alu_ready;
    logic                     ld_issue;
    logic [ADDR_WIDTH-1:0]    ld_rd;
    logic [2:0]               ld_type;
    logic [1:0]               ld_offset;
    logic                     ld_issue_ready;
    logic                     ld_rsp_valid;
    logic [DATA_WIDTH-1:0]    ld_rsp_data;
    logic [ADDR_WIDTH-1:0]    a3;
    logic                     wen3;
    logic [DATA_WIDTH-1:0]    wd3;
    logic [2**ADDR_WIDTH-1:0] busy;
    logic                     ld_err;
`ifdef CPU_WB_BYPASS_EN
    logic                     byp_valid;
    logic [ADDR_WIDTH-1:0]    byp_rd;
    logic [DATA_WIDTH-1:0]    byp_data;
`endif

    modport slave (
`ifdef CPU_WB_BYPASS_EN
        output byp_valid, byp_rd, byp_data,
`endif
        input  alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_type, ld_offset,
               ld_rsp_valid, ld_rsp_data,
        output alu_ready, ld_issue_ready, a3, wen3, wd3, busy, ld_err
    );

    modport master (
`ifdef CPU_WB_BYPASS_EN
        input  byp_valid, byp_rd, byp_data,
`endif
        output alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_type, ld_offset,
               ld_rsp_valid, ld_rsp_data,
        input  alu_ready, ld_issue_ready, a3, wen3, wd3, busy, ld_err
    );

endinterface

// File: rtl/cpu_wb_ldq.sv
// In-order outstanding-load queue; also exposes per-slot valid/rd so the top can build the busy map.
module cpu_wb_ldq
    import cpu_wb_unit_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  lq_entry_t                 pushEntry_i,
    input  logic                      pop_i,
    output lq_entry_t                 head_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [DEPTH-1:0]          entryValid_o,
    output logic [CPU_ADDR_WIDTH-1:0] entryRd_o [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);

    lq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             doPush;
    logic             doPop;

    // A full queue refuses a push even when a pop happens in the same cycle.
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushEntry_i;
        end
    end

    // Slot i is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entryValid_o[i] = ({1'b0, PTR_W'(i) - rdPtr_q} < count_q);
            entryRd_o[i]    = mem_q[i].rd;
        end
    end

endmodule

// File: rtl/cpu_wb_unit.sv
// Writeback driver of the register bank: merges ALU results with in-order load responses.
// Optional macro CPU_WB_BYPASS_EN adds a combinational forward of the selected write.
module cpu_wb_unit
    import cpu_wb_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int LQ_DEPTH   = 4
)
(
    input logic          clk,
    input logic          rst,
    cpu_wb_unit_if.slave bus
);

    lq_entry_t                 pushEntry;
    lq_entry_t                 head;
    logic                      lqFull;
    logic                      lqEmpty;
    logic                      lqPush;
    logic                      lqPop;
    logic [LQ_DEPTH-1:0]       entryValid;
    logic [CPU_ADDR_WIDTH-1:0] entryRd [LQ_DEPTH];

    logic                      selValid;
    logic [ADDR_WIDTH-1:0]     selRd;
    logic [DATA_WIDTH-1:0]     selData;
    logic                      wen3_q, wen3_d;
    logic [ADDR_WIDTH-1:0]     a3_q, a3_d;
    logic [DATA_WIDTH-1:0]     wd3_q, wd3_d;
    logic                      ldErr_q, ldErr_d;
    logic [2**ADDR_WIDTH-1:0]  busyVec;

    assign bus.ld_issue_ready = !lqFull;
    assign bus.alu_ready      = !bus.ld_rsp_valid;
    assign lqPush             = bus.ld_issue && !lqFull;
    assign lqPop              = bus.ld_rsp_valid && !lqEmpty;
    assign pushEntry          = '{rd:     CPU_ADDR_WIDTH'(bus.ld_rd),
                                  ltype:  lq_type_t'(bus.ld_type),
                                  offset: bus.ld_offset};

    cpu_wb_ldq #(
        .DEPTH (LQ_DEPTH)
    ) u_ldq (
        .clk          (clk),
        .rst          (rst),
        .push_i       (lqPush),
        .pushEntry_i  (pushEntry),
        .pop_i        (lqPop),
        .head_o       (head),
        .full_o       (lqFull),
        .empty_o      (lqEmpty),
        .entryValid_o (entryValid),
        .entryRd_o    (entryRd)
    );

    // Load responses cannot be stalled, so they always win the single write port.
    always_comb begin
        selValid = 1'b0;
        selRd    = '0;
        selData  = '0;
        ldErr_d  = ldErr_q;
        if (bus.ld_rsp_valid) begin
            if (!lqEmpty) begin
                selValid = 1'b1;
                selRd    = ADDR_WIDTH'(head.rd);
                selData  = DATA_WIDTH'(lq_format(head.ltype, head.offset,
                                                 CPU_DATA_WIDTH'(bus.ld_rsp_data)));
            end else begin
                ldErr_d  = 1'b1;
            end
        end else if (bus.alu_valid) begin
            selValid = 1'b1;
            selRd    = bus.alu_rd;
            selData  = bus.alu_data;
        end
        wen3_d = selValid && (selRd != '0);
        a3_d   = wen3_d ? selRd : '0;
        wd3_d  = wen3_d ? selData : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen3_q  <= 1'b0;
            a3_q    <= '0;
            wd3_q   <= '0;
            ldErr_q <= 1'b0;
        end else begin
            wen3_q  <= wen3_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
            ldErr_q <= ldErr_d;
        end
    end

    // Built from registered queue state, so a bit drops the cycle the matching write lands.
    always_comb begin
        busyVec = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (entryValid[i]) begin
                busyVec[ADDR_WIDTH'(entryRd[i])] = 1'b1;
            end
        end
        busyVec[0] = 1'b0;
    end

    assign bus.wen3   = wen3_q;
    assign bus.a3     = a3_q;
    assign bus.wd3    = wd3_q;
    assign bus.ld_err = ldErr_q;
    assign bus.busy   = busyVec;

`ifdef CPU_WB_BYPASS_EN
    assign bus.byp_valid = wen3_d;
    assign bus.byp_rd    = selRd;
    assign bus.byp_data  = selData;
`endif

endmodule

// File: tb/tb_cpu_wb_unit.sv
// Directed, table-driven bench for cpu_wb_unit plus hand-written queue-full and reset sequences.
module tb_cpu_wb_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cpu_wb_unit_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    cpu_wb_unit #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .LQ_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        aluValid;
        logic [4:0]  aluRd;
        logic [31:0] aluData;
        logic        ldIssue;
        logic [4:0]  ldRd;
        logic [2:0]  ldType;
        logic [1:0]  ldOffset;
        logic        rspValid;
        logic [31:0] rspData;
        logic        expAluReady;
        logic        expIssueReady;
        logic        expWen3;
        logic [4:0]  expA3;
        logic [31:0] expWd3;
        logic [31:0] expBusy;
        logic        expErr;
    } vector_t;

    vector_t vecs[$];

    function automatic vector_t vec(
        input logic aV, input logic [4:0] aRd, input logic [31:0] aD,
        input logic lI, input logic [4:0] lRd, input logic [2:0] lT, input logic [1:0] lO,
        input logic rV, input logic [31:0] rD,
        input logic eAR, input logic eIR, input logic eW, input logic [4:0] eA3,
        input logic [31:0] eWd, input logic [31:0] eB, input logic eE
    );
        vector_t v;
        v.aluValid = aV;  v.aluRd = aRd; v.aluData = aD;
        v.ldIssue = lI;   v.ldRd = lRd;  v.ldType = lT; v.ldOffset = lO;
        v.rspValid = rV;  v.rspData = rD;
        v.expAluReady = eAR; v.expIssueReady = eIR; v.expWen3 = eW; v.expA3 = eA3;
        v.expWd3 = eWd;   v.expBusy = eB; v.expErr = eE;
        return v;
    endfunction

    task automatic clearInputs();
        bus.alu_valid    = 1'b0;
        bus.alu_rd       = '0;
        bus.alu_data     = '0;
        bus.ld_issue     = 1'b0;
        bus.ld_rd        = '0;
        bus.ld_type      = '0;
        bus.ld_offset    = '0;
        bus.ld_rsp_valid = 1'b0;
        bus.ld_rsp_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vector_t v);
        tick();
        bus.alu_valid    = v.aluValid;
        bus.alu_rd       = v.aluRd;
        bus.alu_data     = v.aluData;
        bus.ld_issue     = v.ldIssue;
        bus.ld_rd        = v.ldRd;
        bus.ld_type      = v.ldType;
        bus.ld_offset    = v.ldOffset;
        bus.ld_rsp_valid = v.rspValid;
        bus.ld_rsp_data  = v.rspData;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkWrite(input string name, input logic [4:0] a3, input logic [31:0] wd3);
        checkOutput({name, ".wen3"}, 32'(bus.wen3), 32'd1);
        checkOutput({name, ".a3"}, 32'(bus.a3), 32'(a3));
        checkOutput({name, ".wd3"}, bus.wd3, wd3);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Row inputs apply for one cycle; registered outputs show the previous row's acceptance.
        vecs.push_back(vec(0,0,0,          0,0,0,0, 0,0,            1,1,0,0,0,            0,0));
        vecs.push_back(vec(1,5,32'hDEADBEEF,0,0,0,0, 0,0,           1,1,0,0,0,            0,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 0,0,            1,1,1,5,32'hDEADBEEF, 0,0));
        vecs.push_back(vec(0,0,0,          1,3,3'b000,2, 0,0,       1,1,0,0,0,            0,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 0,0,            1,1,0,0,0,            32'h8,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 1,32'h00800000, 0,1,0,0,0,            32'h8,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 0,0,            1,1,1,3,32'hFFFFFF80, 0,0));
        vecs.push_back(vec(0,0,0,          1,7,3'b101,2, 0,0,       1,1,0,0,0,            0,0));
        vecs.push_back(vec(1,9,32'h12345678,0,0,0,0, 1,32'h80010000, 0,1,0,0,0,           32'h80,0));
        vecs.push_back(vec(1,9,32'h12345678,0,0,0,0, 0,0,           1,1,1,7,32'h00008001, 0,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 0,0,            1,1,1,9,32'h12345678, 0,0));
        vecs.push_back(vec(1,0,32'hFFFFFFFF,0,0,0,0, 0,0,           1,1,0,0,0,            0,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 0,0,            1,1,0,0,0,            0,0));
        vecs.push_back(vec(0,0,0,          1,10,3'b001,0, 0,0,      1,1,0,0,0,            0,0));
        vecs.push_back(vec(0,0,0,          1,11,3'b100,1, 0,0,      1,1,0,0,0,            32'h400,0));
        vecs.push_back(vec(0,0,0,          1,12,3'b010,3, 0,0,      1,1,0,0,0,            32'hC00,0));
        vecs.push_back(vec(0,0,0,          1,13,3'b111,1, 0,0,      1,1,0,0,0,            32'h1C00,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 1,32'h12348765, 0,0,0,0,0,            32'h3C00,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 1,32'h0000F000, 0,1,1,10,32'hFFFF8765,32'h3800,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 1,32'hCAFEBABE, 0,1,1,11,32'h000000F0,32'h3000,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 1,32'h80000001, 0,1,1,12,32'hCAFEBABE,32'h2000,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 0,0,            1,1,1,13,32'h80000001,0,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 1,32'h11111111, 0,1,0,0,0,            0,0));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 0,0,            1,1,0,0,0,            0,1));
        vecs.push_back(vec(1,6,32'h55,     0,0,0,0, 0,0,            1,1,0,0,0,            0,1));
        vecs.push_back(vec(0,0,0,          0,0,0,0, 0,0,            1,1,1,6,32'h55,       0,1));

        clearInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.wen3", 32'(bus.wen3), 32'd0);
        checkOutput("reset.a3", 32'(bus.a3), 32'd0);
        checkOutput("reset.wd3", bus.wd3, 32'd0);
        checkOutput("reset.busy", bus.busy, 32'd0);
        checkOutput("reset.ld_err", 32'(bus.ld_err), 32'd0);
        checkOutput("reset.ld_issue_ready", 32'(bus.ld_issue_ready), 32'd1);
        tick();
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("row%0d.alu_ready", i), 32'(bus.alu_ready), 32'(vecs[i].expAluReady));
            checkOutput($sformatf("row%0d.ld_issue_ready", i), 32'(bus.ld_issue_ready), 32'(vecs[i].expIssueReady));
            checkOutput($sformatf("row%0d.wen3", i), 32'(bus.wen3), 32'(vecs[i].expWen3));
            checkOutput($sformatf("row%0d.busy", i), bus.busy, vecs[i].expBusy);
            checkOutput($sformatf("row%0d.ld_err", i), 32'(bus.ld_err), 32'(vecs[i].expErr));
            if (vecs[i].expWen3) begin
                checkOutput($sformatf("row%0d.a3", i), 32'(bus.a3), 32'(vecs[i].expA3));
                checkOutput($sformatf("row%0d.wd3", i), bus.wd3, vecs[i].expWd3);
            end
        end

        // Fill the queue, then respond while still issuing: only the pop may happen.
        for (int k = 0; k < 4; k++) begin
            tick();
            clearInputs();
            bus.ld_issue = 1'b1;
            bus.ld_rd    = 5'(20 + k);
            bus.ld_type  = 3'b010;
            @(negedge clk);
            checkOutput($sformatf("fill%0d.ld_issue_ready", k), 32'(bus.ld_issue_ready), 32'd1);
        end
        tick();
        clearInputs();
        @(negedge clk);
        checkOutput("full.ld_issue_ready", 32'(bus.ld_issue_ready), 32'd0);
        checkOutput("full.busy", bus.busy, 32'h00F00000);
        tick();
        bus.ld_issue     = 1'b1;
        bus.ld_rd        = 5'd24;
        bus.ld_type      = 3'b010;
        bus.ld_rsp_valid = 1'b1;
        bus.ld_rsp_data  = 32'hA0;
        @(negedge clk);
        checkOutput("fullPop.ld_issue_ready", 32'(bus.ld_issue_ready), 32'd0);
        checkOutput("fullPop.alu_ready", 32'(bus.alu_ready), 32'd0);
        tick();
        clearInputs();
        @(negedge clk);
        checkOutput("afterPop.ld_issue_ready", 32'(bus.ld_issue_ready), 32'd1);
        checkOutput("afterPop.busy", bus.busy, 32'h00E00000);
        checkWrite("afterPop", 5'd20, 32'hA0);
        for (int k = 1; k < 4; k++) begin
            tick();
            bus.ld_rsp_valid = 1'b1;
            bus.ld_rsp_data  = 32'hA0 + 32'(k);
            tick();
            clearInputs();
            @(negedge clk);
            checkWrite($sformatf("drain%0d", k), 5'(20 + k), 32'hA0 + 32'(k));
        end
        tick();
        @(negedge clk);
        checkOutput("drained.busy", bus.busy, 32'd0);
        checkOutput("drained.wen3", 32'(bus.wen3), 32'd0);

        // Asynchronous reset while a write is on the port and a load is queued.
        tick();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd8;
        bus.alu_data  = 32'h99;
        bus.ld_issue  = 1'b1;
        bus.ld_rd     = 5'd5;
        bus.ld_type   = 3'b010;
        tick();
        clearInputs();
        @(negedge clk);
        checkWrite("preReset", 5'd8, 32'h99);
        checkOutput("preReset.busy", bus.busy, 32'h20);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midReset.wen3", 32'(bus.wen3), 32'd0);
        checkOutput("midReset.a3", 32'(bus.a3), 32'd0);
        checkOutput("midReset.wd3", bus.wd3, 32'd0);
        checkOutput("midReset.busy", bus.busy, 32'd0);
        checkOutput("midReset.ld_err", 32'(bus.ld_err), 32'd0);
        checkOutput("midReset.ld_issue_ready", 32'(bus.ld_issue_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        bus.ld_rsp_valid = 1'b1;
        bus.ld_rsp_data  = 32'h77;
        tick();
        clearInputs();
        @(negedge clk);
        checkOutput("postReset.wen3", 32'(bus.wen3), 32'd0);
        checkOutput("postReset.ld_err", 32'(bus.ld_err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
